// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline widths, register-index/word types and the r0 index
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/wb_regfile_array.sv
// rtl/wb_regfile_array.sv - regfile_array: 2**ADDR_W x DATA_W storage, one write port, two async reads
// Index 0 is never written and always reads zero.
module regfile_array
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wn != ZERO_IDX)) begin
            regs[wn] <= wd;
        end
    end

    // r0 is forced at the read side so the stored entry never matters
    always_comb begin
        qa = (rs == ZERO_IDX) ? '0 : regs[rs];
        qb = (rt == ZERO_IDX) ? '0 : regs[rt];
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - WB result mux, register file write/read, retired-write counter
// Optional write-through to the ID read ports under macro WB_BYPASS_EN.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              WBwreg,
    input  logic              WBm2reg,
    input  logic [ADDR_W-1:0] WBwn,
    input  logic [DATA_W-1:0] WBaluResult,
    input  logic [DATA_W-1:0] WBmemOut,
    input  logic [ADDR_W-1:0] IDrs,
    input  logic [ADDR_W-1:0] IDrt,
    output logic [DATA_W-1:0] IDqa,
    output logic [DATA_W-1:0] IDqb,
    output logic [DATA_W-1:0] WBwdata,
    output logic              WBwe,
    output logic [CNT_W-1:0]  wbCount
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] rf_qa;
    logic [DATA_W-1:0] rf_qb;

    assign WBwdata = WBm2reg ? WBmemOut : WBaluResult;
    assign WBwe    = WBwreg && (WBwn != ZERO_IDX);

    regfile_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk (clk),
        .clr (clr),
        .we  (WBwe),
        .wn  (WBwn),
        .wd  (WBwdata),
        .rs  (IDrs),
        .rt  (IDrt),
        .qa  (rf_qa),
        .qb  (rf_qb)
    );

`ifdef WB_BYPASS_EN
    // WBwe is already false for r0, so the bypass cannot leak into index 0
    always_comb begin
        IDqa = (WBwe && (IDrs == WBwn)) ? WBwdata : rf_qa;
        IDqb = (WBwe && (IDrt == WBwn)) ? WBwdata : rf_qb;
    end
`else
    always_comb begin
        IDqa = rf_qa;
        IDqb = rf_qb;
    end
`endif

    // Wraps silently at 2**CNT_W-1
    always_ff @(posedge clk) begin
        if (clr) begin
            wbCount <= '0;
        end else if (WBwe) begin
            wbCount <= wbCount + CNT_ONE;
        end
    end

endmodule
